ahb_arbiter: RTL and testbench

Three-master AHB bus arbiter and master-side multiplexer for the KRV AHB fabric. It grants bus ownership among IAHB (M0), DAHB (M1) and the reserved port (M2), and holds grants across locked sequences and fixed-length bursts. It drives the muxed address/control and write data (HADDR_M, HTRANS_M, …, HWDATA_M) that feed `ahb_decoder`, and takes the returned HREADY_S/HRESP_S as its bus-state inputs.

---
 rtl/ahb_arbiter_pkg.sv | 26 ++
 rtl/ahb_arb_sel.sv | 25 ++
 rtl/ahb_arbiter.sv | 111 +++++++++++
 tb/tb_ahb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arbiter_pkg.sv
// ahb_arbiter_pkg: shared AHB encodings, bus widths and the burst-length helper.
// The width macros replace a separate ahb_defines.vh and may be predefined by the build.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package ahb_arbiter_pkg;
    typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_e;
    typedef enum logic [2:0] {
        HBURST_SINGLE, HBURST_INCR, HBURST_WRAP4, HBURST_INCR4,
        HBURST_WRAP8, HBURST_INCR8, HBURST_WRAP16, HBURST_INCR16
    } hburst_e;
    typedef enum logic [1:0] {HRESP_OKAY, HRESP_ERROR, HRESP_RETRY, HRESP_SPLIT} hresp_e;

    // Beats still to come after the NONSEQ: 0, 3, 7 or 15 from HBURST[2:1]
    function automatic logic [3:0] burst_load(input logic [2:0] hburst);
        return hburst[2:1] == 2'b00 ? 4'd0 : {hburst[2] & hburst[1], hburst[2], 2'b11};
    endfunction

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return i == 2'd2 ? 2'd0 : i + 2'd1;
    endfunction
endpackage

// File: rtl/ahb_arb_sel.sv
// ahb_arb_sel: combinational request-to-master selector.
// Fixed priority M1 > M0 > M2 by default; round-robin from ptr+1 when AHB_ARB_RR_EN is defined.
module ahb_arb_sel
    import ahb_arbiter_pkg::*;
#(
    parameter logic [1:0] DEFAULT_MASTER = 2'd0
) (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] sel
);
`ifdef AHB_ARB_RR_EN
    logic [1:0] s1, s2, s3;
    always_comb begin
        s1 = next_idx(ptr);
        s2 = next_idx(s1);
        s3 = next_idx(s2);
        sel = req[s1] ? s1 : req[s2] ? s2 : req[s3] ? s3 : DEFAULT_MASTER;
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign sel = req[1] ? 2'd1 : req[0] ? 2'd0 : req[2] ? 2'd2 : DEFAULT_MASTER;
`endif
endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: three-master AHB arbiter with lock/burst grant holding and master-side muxes.
// Define AHB_ARB_RR_EN for round-robin selection instead of fixed priority.
module ahb_arbiter
    import ahb_arbiter_pkg::*;
#(
    parameter logic [1:0] DEFAULT_MASTER = 2'd0
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       HBUSREQ_M0,
    input  logic                       HBUSREQ_M1,
    input  logic                       HBUSREQ_M2,
    input  logic                       HLOCK_M0,
    input  logic                       HLOCK_M1,
    input  logic                       HLOCK_M2,
    output logic                       HGRANT_M0,
    output logic                       HGRANT_M1,
    output logic                       HGRANT_M2,
    input  logic [`AHB_ADDR_WIDTH-1:0] HADDR_M0,
    input  logic [`AHB_ADDR_WIDTH-1:0] HADDR_M1,
    input  logic [`AHB_ADDR_WIDTH-1:0] HADDR_M2,
    input  logic [1:0]                 HTRANS_M0,
    input  logic [1:0]                 HTRANS_M1,
    input  logic [1:0]                 HTRANS_M2,
    input  logic                       HWRITE_M0,
    input  logic                       HWRITE_M1,
    input  logic                       HWRITE_M2,
    input  logic [2:0]                 HSIZE_M0,
    input  logic [2:0]                 HSIZE_M1,
    input  logic [2:0]                 HSIZE_M2,
    input  logic [2:0]                 HBURST_M0,
    input  logic [2:0]                 HBURST_M1,
    input  logic [2:0]                 HBURST_M2,
    input  logic [`AHB_DATA_WIDTH-1:0] HWDATA_M0,
    input  logic [`AHB_DATA_WIDTH-1:0] HWDATA_M1,
    input  logic [`AHB_DATA_WIDTH-1:0] HWDATA_M2,
    output logic [`AHB_ADDR_WIDTH-1:0] HADDR_M,
    output logic [1:0]                 HTRANS_M,
    output logic                       HWRITE_M,
    output logic [2:0]                 HSIZE_M,
    output logic [2:0]                 HBURST_M,
    output logic [`AHB_DATA_WIDTH-1:0] HWDATA_M,
    input  logic                       HREADY_S,
    input  logic [1:0]                 HRESP_S,
    output logic [1:0]                 HMASTER,
    output logic                       HMASTLOCK
);
    logic [2:0] req, lock;
    logic [1:0] grant, sel, ptr, hmaster_d;
    logic [3:0] cnt, cnt_nxt;
    logic       held;

    assign req  = {HBUSREQ_M2, HBUSREQ_M1, HBUSREQ_M0};
    assign lock = {HLOCK_M2, HLOCK_M1, HLOCK_M0};

    ahb_arb_sel #(.DEFAULT_MASTER(DEFAULT_MASTER)) u_sel (
        .req(req),
        .ptr(ptr),
        .sel(sel)
    );

    always_comb begin
        cnt_nxt = HTRANS_M == HTRANS_NONSEQ ? burst_load(HBURST_M) :
                  HTRANS_M == HTRANS_SEQ    ? (cnt == 4'd0 ? 4'd0 : cnt - 4'd1) :
                  HTRANS_M == HTRANS_IDLE   ? 4'd0 : cnt;
        held = lock[grant] || cnt_nxt != 4'd0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant     <= DEFAULT_MASTER;
            HMASTER   <= DEFAULT_MASTER;
            hmaster_d <= DEFAULT_MASTER;
            HMASTLOCK <= 1'b0;
            cnt       <= 4'd0;
        end else if (HREADY_S) begin
            cnt       <= cnt_nxt;
            grant     <= held ? grant : sel;
            HMASTER   <= grant;
            HMASTLOCK <= lock[grant];
            hmaster_d <= HMASTER;
        end else if (HRESP_S != HRESP_OKAY) begin
            cnt <= 4'd0;
        end
    end

`ifdef AHB_ARB_RR_EN
    // Pointer tracks the last master actually handed the bus on request, not idle defaults
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            ptr <= DEFAULT_MASTER;
        else if (HREADY_S && !held && sel != grant && req[sel])
            ptr <= sel;
    end
`else
    assign ptr = DEFAULT_MASTER;
`endif

    assign HGRANT_M0 = grant == 2'd0;
    assign HGRANT_M1 = grant == 2'd1;
    assign HGRANT_M2 = grant == 2'd2;

    always_comb begin
        HADDR_M  = HMASTER == 2'd1 ? HADDR_M1  : HMASTER == 2'd2 ? HADDR_M2  : HADDR_M0;
        HTRANS_M = HMASTER == 2'd1 ? HTRANS_M1 : HMASTER == 2'd2 ? HTRANS_M2 : HTRANS_M0;
        HWRITE_M = HMASTER == 2'd1 ? HWRITE_M1 : HMASTER == 2'd2 ? HWRITE_M2 : HWRITE_M0;
        HSIZE_M  = HMASTER == 2'd1 ? HSIZE_M1  : HMASTER == 2'd2 ? HSIZE_M2  : HSIZE_M0;
        HBURST_M = HMASTER == 2'd1 ? HBURST_M1 : HMASTER == 2'd2 ? HBURST_M2 : HBURST_M0;
        HWDATA_M = hmaster_d == 2'd1 ? HWDATA_M1 : hmaster_d == 2'd2 ? HWDATA_M2 : HWDATA_M0;
    end
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scenarios plus a randomized run against a transaction-level arbiter model.
module tb_ahb_arbiter;
    localparam int AW = `AHB_ADDR_WIDTH;
    localparam int DW = `AHB_DATA_WIDTH;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic [2:0] busreq = 3'b000;
    logic [2:0] hlock = 3'b000;
    logic [1:0] htrans [3];
    logic       hwrite [3];
    logic [2:0] hsize  [3];
    logic [2:0] hburst [3];
    logic [AW-1:0] haddr  [3];
    logic [DW-1:0] hwdata [3];
    logic       HREADY_S = 1'b1;
    logic [1:0] HRESP_S = 2'b00;
    logic [2:0] gnt;
    logic [AW-1:0] HADDR_M;
    logic [1:0] HTRANS_M;
    logic       HWRITE_M;
    logic [2:0] HSIZE_M, HBURST_M;
    logic [DW-1:0] HWDATA_M;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    int checks = 0;
    int fails = 0;

    always #5 HCLK = ~HCLK;

    ahb_arbiter dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HBUSREQ_M0(busreq[0]), .HBUSREQ_M1(busreq[1]), .HBUSREQ_M2(busreq[2]),
        .HLOCK_M0(hlock[0]), .HLOCK_M1(hlock[1]), .HLOCK_M2(hlock[2]),
        .HGRANT_M0(gnt[0]), .HGRANT_M1(gnt[1]), .HGRANT_M2(gnt[2]),
        .HADDR_M0(haddr[0]), .HADDR_M1(haddr[1]), .HADDR_M2(haddr[2]),
        .HTRANS_M0(htrans[0]), .HTRANS_M1(htrans[1]), .HTRANS_M2(htrans[2]),
        .HWRITE_M0(hwrite[0]), .HWRITE_M1(hwrite[1]), .HWRITE_M2(hwrite[2]),
        .HSIZE_M0(hsize[0]), .HSIZE_M1(hsize[1]), .HSIZE_M2(hsize[2]),
        .HBURST_M0(hburst[0]), .HBURST_M1(hburst[1]), .HBURST_M2(hburst[2]),
        .HWDATA_M0(hwdata[0]), .HWDATA_M1(hwdata[1]), .HWDATA_M2(hwdata[2]),
        .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M),
        .HSIZE_M(HSIZE_M), .HBURST_M(HBURST_M), .HWDATA_M(HWDATA_M),
        .HREADY_S(HREADY_S), .HRESP_S(HRESP_S),
        .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
    );

    // Reference model: who holds the grant, who owns address/data phase, beats left in the burst
    int m_grant, m_owner, m_downer, m_rem, m_last;
    bit m_lock;

    function automatic int burst_beats(logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    function automatic int remaining(int rem, logic [1:0] t, logic [2:0] b);
        if (t == 2'b10) return burst_beats(b) - 1;
        if (t == 2'b11) return rem > 0 ? rem - 1 : 0;
        if (t == 2'b00) return 0;
        return rem;
    endfunction

    function automatic int pick(logic [2:0] r, int last);
`ifdef AHB_ARB_RR_EN
        for (int k = 1; k <= 3; k++) if (r[(last + k) % 3]) return (last + k) % 3;
`else
        if (last < 0) return 0;
        if (r[1]) return 1;
        if (r[0]) return 0;
        if (r[2]) return 2;
`endif
        return 0;
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_grant <= 0; m_owner <= 0; m_downer <= 0; m_lock <= 0; m_rem <= 0; m_last <= 0;
        end else if (HREADY_S) begin
            m_rem <= remaining(m_rem, htrans[m_owner], hburst[m_owner]);
            if (!hlock[m_grant] && remaining(m_rem, htrans[m_owner], hburst[m_owner]) == 0) begin
                m_grant <= pick(busreq, m_last);
                if (pick(busreq, m_last) != m_grant && busreq[pick(busreq, m_last)])
                    m_last <= pick(busreq, m_last);
            end
            m_owner  <= m_grant;
            m_lock   <= hlock[m_grant];
            m_downer <= m_owner;
        end else if (HRESP_S != 2'b00) begin
            m_rem <= 0;
        end
    end

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            htrans[i] = 2'b00; hburst[i] = 3'd0; hwrite[i] = 1'b0; hsize[i] = 3'd2;
            haddr[i] = AW'(32'h1000_0000 * (i + 1)); hwdata[i] = DW'(32'hD000_0000 + i);
        end
    endtask

    task automatic test_reset();
        idle_all();
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        checks++; if (gnt !== 3'b001) begin fails++; $display("FAIL reset_grant: got %b want 001", gnt); end
        checks++; if (HMASTER !== 2'd0) begin fails++; $display("FAIL reset_hmaster: got %0d want 0", HMASTER); end
        checks++; if (HMASTLOCK !== 1'b0) begin fails++; $display("FAIL reset_lock: got %b want 0", HMASTLOCK); end
        checks++; if (HADDR_M !== haddr[0]) begin fails++; $display("FAIL reset_haddr: got %h want %h", HADDR_M, haddr[0]); end
        checks++; if (HWDATA_M !== hwdata[0]) begin fails++; $display("FAIL reset_hwdata: got %h want %h", HWDATA_M, hwdata[0]); end
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    task automatic test_grant_latency();
        busreq = 3'b010;
        @(negedge HCLK);
        checks++; if (gnt !== 3'b010) begin fails++; $display("FAIL req_to_grant: got %b want 010", gnt); end
        checks++; if (HMASTER !== 2'd0) begin fails++; $display("FAIL grant_owner_early: got %0d want 0", HMASTER); end
        @(negedge HCLK);
        checks++; if (HMASTER !== 2'd1) begin fails++; $display("FAIL grant_to_owner: got %0d want 1", HMASTER); end
        checks++; if (HADDR_M !== haddr[1]) begin fails++; $display("FAIL owner_haddr: got %h want %h", HADDR_M, haddr[1]); end
        checks++; if (HWDATA_M !== hwdata[0]) begin fails++; $display("FAIL wdata_lag: got %h want %h", HWDATA_M, hwdata[0]); end
        @(negedge HCLK);
        checks++; if (HWDATA_M !== hwdata[1]) begin fails++; $display("FAIL wdata_follow: got %h want %h", HWDATA_M, hwdata[1]); end
    endtask

    task automatic give_m0();
        idle_all();
        busreq = 3'b001;
        repeat (2) @(negedge HCLK);
    endtask

    task automatic test_burst_hold();
        logic [1:0] seq [4];
        seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b11; seq[3] = 2'b11;
        give_m0();
        hburst[0] = 3'd3;
        for (int k = 0; k < 4; k++) begin
            htrans[0] = seq[k];
            if (k == 1) busreq = 3'b011;
            #1;
            checks++; if (HTRANS_M !== seq[k]) begin fails++; $display("FAIL burst_htrans%0d: got %b want %b", k, HTRANS_M, seq[k]); end
            @(negedge HCLK);
            checks++;
            if (gnt !== (k == 3 ? 3'b010 : 3'b001)) begin
                fails++; $display("FAIL burst_hold%0d: got %b want %b", k, gnt, k == 3 ? 3'b010 : 3'b001);
            end
        end
        idle_all();
    endtask

    task automatic test_wait_states();
        give_m0();
        hburst[0] = 3'd5;
        htrans[0] = 2'b10;
        @(negedge HCLK);
        htrans[0] = 2'b11;
        busreq = 3'b011;
        @(negedge HCLK);
        HREADY_S = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            checks++; if (dut.cnt !== 4'd6) begin fails++; $display("FAIL wait_cnt%0d: got %0d want 6", k, dut.cnt); end
            checks++; if (HMASTER !== 2'd0 || dut.hmaster_d !== 2'd0) begin
                fails++; $display("FAIL wait_owner%0d: got %0d/%0d want 0/0", k, HMASTER, dut.hmaster_d);
            end
        end
        HREADY_S = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge HCLK);
            checks++;
            if (gnt !== (k == 5 ? 3'b010 : 3'b001)) begin
                fails++; $display("FAIL wait_resume%0d: got %b want %b", k, gnt, k == 5 ? 3'b010 : 3'b001);
            end
        end
        idle_all();
    endtask

    task automatic test_lock();
        busreq = 3'b100;
        hlock = 3'b100;
        repeat (2) @(negedge HCLK);
        busreq = 3'b110;
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            checks++; if (gnt !== 3'b100 || HMASTLOCK !== 1'b1) begin
                fails++; $display("FAIL lock_hold%0d: got %b/%b want 100/1", k, gnt, HMASTLOCK);
            end
        end
        hlock = 3'b000;
        @(negedge HCLK);
        checks++; if (gnt !== 3'b010 || HMASTLOCK !== 1'b0) begin
            fails++; $display("FAIL lock_release: got %b/%b want 010/0", gnt, HMASTLOCK);
        end
    endtask

    task automatic test_error();
        give_m0();
        hburst[0] = 3'd5;
        htrans[0] = 2'b10;
        @(negedge HCLK);
        htrans[0] = 2'b11;
        busreq = 3'b011;
        HREADY_S = 1'b0;
        HRESP_S = 2'b01;
        @(negedge HCLK);
        checks++; if (dut.cnt !== 4'd0) begin fails++; $display("FAIL error_cnt: got %0d want 0", dut.cnt); end
        checks++; if (gnt !== 3'b001) begin fails++; $display("FAIL error_wait_grant: got %b want 001", gnt); end
        HREADY_S = 1'b1;
        htrans[0] = 2'b00;
        @(negedge HCLK);
        checks++; if (gnt !== 3'b010) begin fails++; $display("FAIL error_regrant: got %b want 010", gnt); end
        HRESP_S = 2'b00;
        busreq = 3'b000;
        @(negedge HCLK);
    endtask

    task automatic test_rr();
        int want;
        busreq = 3'b110;
        @(negedge HCLK);
        for (int i = 0; i < 3; i++) begin htrans[i] = 2'b10; hburst[i] = 3'd0; end
        busreq = 3'b111;
        for (int k = 0; k < 6; k++) begin
            @(negedge HCLK);
`ifdef AHB_ARB_RR_EN
            want = (k + 2) % 3;
`else
            want = 1;
`endif
            checks++; if (gnt !== 3'(1 << want)) begin
                fails++; $display("FAIL rr_order%0d: got %b want %b", k, gnt, 3'(1 << want));
            end
        end
        idle_all();
        busreq = 3'b000;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge HCLK);
            checks++; if (gnt !== 3'(1 << m_grant)) begin fails++; $display("FAIL rand_grant@%0d: got %b want %b", n, gnt, 3'(1 << m_grant)); end
            checks++; if (HMASTER !== 2'(m_owner) || HMASTLOCK !== m_lock) begin
                fails++; $display("FAIL rand_owner@%0d: got %0d/%b want %0d/%b", n, HMASTER, HMASTLOCK, m_owner, m_lock);
            end
            checks++; if (dut.cnt !== 4'(m_rem)) begin fails++; $display("FAIL rand_cnt@%0d: got %0d want %0d", n, dut.cnt, m_rem); end
            checks++; if (HADDR_M !== haddr[m_owner] || HTRANS_M !== htrans[m_owner] || HBURST_M !== hburst[m_owner]
                          || HSIZE_M !== hsize[m_owner] || HWRITE_M !== hwrite[m_owner]) begin
                fails++; $display("FAIL rand_addrmux@%0d: got %h/%b want %h/%b", n, HADDR_M, HTRANS_M, haddr[m_owner], htrans[m_owner]);
            end
            checks++; if (HWDATA_M !== hwdata[m_downer]) begin fails++; $display("FAIL rand_wdata@%0d: got %h want %h", n, HWDATA_M, hwdata[m_downer]); end
            busreq = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                hlock[i]  = busreq[i] && ($urandom_range(0, 5) == 0);
                htrans[i] = 2'($urandom);
                hburst[i] = 3'($urandom);
                hsize[i]  = 3'($urandom);
                hwrite[i] = 1'($urandom);
                haddr[i]  = AW'($urandom);
                hwdata[i] = DW'($urandom);
            end
            HREADY_S = $urandom_range(0, 4) != 0;
            HRESP_S = (!HREADY_S && $urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
        idle_all();
        hlock = 3'b000;
        busreq = 3'b000;
        HREADY_S = 1'b1;
        HRESP_S = 2'b00;
        repeat (2) @(negedge HCLK);
    endtask

    task automatic test_reset_mid_burst();
        busreq = 3'b010;
        repeat (2) @(negedge HCLK);
        hburst[1] = 3'd7;
        htrans[1] = 2'b10;
        @(negedge HCLK);
        htrans[1] = 2'b11;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        checks++; if (gnt !== 3'b001 || HMASTER !== 2'd0 || dut.cnt !== 4'd0) begin
            fails++; $display("FAIL reset_abort: got %b/%0d/%0d want 001/0/0", gnt, HMASTER, dut.cnt);
        end
        checks++; if (HADDR_M !== haddr[0] || HWDATA_M !== hwdata[0]) begin
            fails++; $display("FAIL reset_abort_mux: got %h/%h want %h/%h", HADDR_M, HWDATA_M, haddr[0], hwdata[0]);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    initial begin
        test_reset();
        test_grant_latency();
        test_burst_hold();
        test_wait_states();
        test_error();
        test_lock();
        test_rr();
        test_random();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
